reg_writeback_queue: RTL
========================

// Module: reg_writeback_queue
// PURPOSE
//  Write-side feeder for the 32x32 register file. Buffers results from execution units
//  (ALU and load unit) as {addr,data} pairs in a small FIFO. Drains at most one entry
//  per clock onto the register file write port (writeAddr/writeData/writeEn).
//  Optionally returns queued values to the decode stage before they land.
// PARAMETERS
//  DEPTH      4   queue entries; power of 2, >= 2
//  ADDR_W     5   register address width (32 registers)
//  DATA_W     32  register data width
// PORTS
//  clk        in   1       single clock; all state updates on posedge
//  resetN     in   1       asynchronous reset, active-low
//  pushValid  in   1       producer has a result
//  pushAddr   in   ADDR_W  destination register
//  pushData   in   DATA_W  result value
//  pushReady  out  1       queue accepts push this cycle
//  drainEn    in   1       register file write port available this cycle
//  writeAddr  out  ADDR_W  to register file writeAddr
//  writeData  out  DATA_W  to register file writeData
//  writeEn    out  1       to register file writeEn
//  lookAddr1  in   ADDR_W  forwarding lookup address, port 1
//  lookAddr2  in   ADDR_W  forwarding lookup address, port 2
//  lookHit1   out  1       lookAddr1 is pending in queue
//  lookHit2   out  1       lookAddr2 is pending in queue
//  lookData1  out  DATA_W  youngest pending value for lookAddr1
//  lookData2  out  DATA_W  youngest pending value for lookAddr2
//  count      out  clog2(DEPTH)+1  occupied entries
// BEHAVIOUR
//  - Reset (resetN=0, async): head/tail pointers=0, count=0.
//    writeEn=0, writeAddr=0, writeData=0, lookHit*=0, lookData*=0, pushReady=1.
//  - Push handshake: push fires when pushValid & pushReady at posedge.
//    Entry lands at tail, tail=tail+1 mod DEPTH.
//  - pushAddr==0: handshake completes but nothing is enqueued; count unchanged ($zero is read-only).
//  - Drain: writeEn = drainEn & (count!=0), combinational from head entry.
//    writeAddr/writeData = head entry when count!=0, else 0.
//    A pop occurs at the posedge where writeEn=1; head=head+1 mod DEPTH.
//  - Latency: a push into an empty queue with drainEn=1 appears on writeEn the next cycle.
//    The register file commits it on the following posedge.
//  - pushReady = (count<DEPTH) | writeEn. When full, a simultaneous pop frees the slot.
//  - Push and pop in the same cycle: count unchanged, FIFO order preserved.
//  - count next = count + push_enq - pop; never exceeds DEPTH, never wraps below 0.
//  - Pointer wrap is modulo DEPTH; full/empty are decided by count, not pointer compare.
//  - Reset mid-operation: all queued entries are discarded. They are never written.
//  - Data is not altered, merged or coalesced. Duplicate addrs each drain in order.
// CONFIGURATION
//  REGWB_FORWARD_EN defined:
//  - lookHitN=1 iff some occupied entry has addr==lookAddrN and lookAddrN!=0.
//  - lookDataN = youngest (closest to tail) matching entry.
//  - The head entry being drained this cycle still counts as a hit.
//  - The entry being pushed this cycle is not visible until the next cycle.
//  - Combinational outputs.
//  REGWB_FORWARD_EN undefined:
//  - Ports remain; lookHit*=0 and lookData*=0 constantly.
//  - No compare logic is synthesised.
// TESTING
//  1 Reset: resetN=0 mid-run with count=3 -> count=0, writeEn=0, pushReady=1 immediately.
//    No write occurs after release.
//  2 Push {5,0xDEADBEEF} with drainEn=1 -> next cycle writeEn=1, writeAddr=5,
//    writeData=0xDEADBEEF; count returns to 0.
//  3 drainEn=0, push 4 entries (addr 1..4) -> count=4, pushReady=0.
//    Then drainEn=1 -> writes drain 1,2,3,4 in order.
//  4 Full queue, drainEn=1, pushValid=1 {7,0x77} -> push accepted same cycle, count stays 4.
//    0x77 drains after the existing 4.
//  5 Push {0,0x1234} -> pushReady=1, count unchanged, no writeEn ever carries addr 0.
//  6 FORWARD_EN, drainEn=0: push {9,0x11} then {9,0x22}, lookAddr1=9 -> lookHit1=1,
//    lookData1=0x22. lookAddr2=0 -> lookHit2=0.
//    Without the macro -> both hits 0.

Source files
------------

// File: rtl/reg_writeback_queue.sv
// Result FIFO feeding the register file write port, drained one entry per clock.
// Optional forwarding of pending values to decode is enabled by defining REGWB_FORWARD_EN.
module reg_writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic                     pushValid,
  input  logic [ADDR_W-1:0]        pushAddr,
  input  logic [DATA_W-1:0]        pushData,
  output logic                     pushReady,
  input  logic                     drainEn,
  output logic [ADDR_W-1:0]        writeAddr,
  output logic [DATA_W-1:0]        writeData,
  output logic                     writeEn,
  input  logic [ADDR_W-1:0]        lookAddr1,
  input  logic [ADDR_W-1:0]        lookAddr2,
  output logic                     lookHit1,
  output logic                     lookHit2,
  output logic [DATA_W-1:0]        lookData1,
  output logic [DATA_W-1:0]        lookData2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic              occupied;
  logic              pop;
  logic              push_fire;
  logic              push_enq;

  assign occupied  = (count != '0);
  assign pop       = drainEn & occupied;
  assign writeEn   = pop;
  assign writeAddr = occupied ? addr_mem[head] : '0;
  assign writeData = occupied ? data_mem[head] : '0;

  // A pop in the same cycle frees a slot, so a full queue can still accept.
  assign pushReady = (count < FULL) | pop;
  assign push_fire = pushValid & pushReady;
  // $zero is read-only: complete the handshake but drop the entry.
  assign push_enq  = push_fire & (pushAddr != '0);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_enq) tail <= tail + PTR_W'(1);
      if (pop)      head <= head + PTR_W'(1);
      count <= count + CNT_W'(push_enq) - CNT_W'(pop);
    end
  end

  // Storage needs no reset; only occupied slots are ever observed.
  always_ff @(posedge clk) begin
    if (push_enq) begin
      addr_mem[tail] <= pushAddr;
      data_mem[tail] <= pushData;
    end
  end

`ifdef REGWB_FORWARD_EN
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      logic [ADDR_W-1:0] look_addr;
      logic              hit;
      logic [DATA_W-1:0] data;

      assign look_addr = (gi == 0) ? lookAddr1 : lookAddr2;

      // Scan oldest to youngest so the youngest match wins.
      always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int k = 0; k < DEPTH; k++) begin
          if ((CNT_W'(k) < count) && (look_addr != '0) &&
              (addr_mem[head + PTR_W'(k)] == look_addr)) begin
            hit  = 1'b1;
            data = data_mem[head + PTR_W'(k)];
          end
        end
      end
    end
  endgenerate

  assign lookHit1  = g_fwd[0].hit;
  assign lookData1 = g_fwd[0].data;
  assign lookHit2  = g_fwd[1].hit;
  assign lookData2 = g_fwd[1].data;
`else
  logic unused_look;
  assign unused_look = ^{lookAddr1, lookAddr2};
  assign lookHit1  = 1'b0;
  assign lookHit2  = 1'b0;
  assign lookData1 = '0;
  assign lookData2 = '0;
`endif

endmodule
